div_pipe_unit: RTL
==================

Name: div_pipe_unit

Overview:
- 8-stage, fully pipelined 32-bit integer divider for RV32M DIV/DIVU/REM/REMU.
- Sits beside the execute stage. It accepts one divide op per cycle from the decode→execute register (is_div_op, div_signed, div_get_rem, rd, forwarded operands).
- Delivers the result to writeback exactly 8 cycles later.
- Exports per-stage occupancy (div_busy_0..7) so decode can stall dependent instructions and avoid writeback collisions.

Parameters:
- WIDTH, 32, operand/result width
- STAGES, 8, pipeline depth; fixed at 8 (decode hazard logic depends on it)
- BITS_PER_STAGE, 4, quotient bits resolved per stage (WIDTH/STAGES)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  issue a divide op this cycle
- in_signed  input  1  1=DIV/REM, 0=DIVU/REMU
- in_get_rem  input  1  1=remainder, 0=quotient
- in_rd  input  5  destination register
- in_dividend  input  32  rs1 value (already forwarded)
- in_divisor  input  32  rs2 value (already forwarded)
- div_busy_0 .. div_busy_7  output  7 each  {valid, 1'b0, rd} of stage k register
- out_valid  output  1  result available this cycle
- out_rd  output  5  destination of result
- out_result  output  32  final quotient or remainder

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high: rst.
- No backpressure, no flush; throughput 1 op/cycle. Decode guarantees no structural conflict at writeback.
- Stage register k (k=0..7) holds: valid, signed, get_rem, rd, dividend sign, divisor sign, div_by_zero flag, |divisor|, partial remainder (33 bits), quotient/shift register (32 bits).
- Stage 0 input logic, combinational from in_*:
  - take magnitudes (negate if in_signed and MSB=1; 0x80000000 stays 0x80000000 as unsigned 2^31);
  - set div_by_zero = (in_divisor==0);
  - perform restoring iterations 1-4;
  - capture on clk edge.
- Stage k≥1: performs iterations 4k+1..4k+4 on stage k-1 contents; captures into stage k.
- Restoring iteration: rem = {rem[31:0], q[31]}; q <<= 1. If rem ≥ |divisor|: rem -= |divisor| and set q[0]=1.
- Latency: op with in_valid=1 at edge t is in stage k after edge t+k. out_valid=1 in the cycle after edge t+7 (8 cycles from issue).
- Output logic, combinational from stage 7:
  - Quotient sign fix: negate if signed and sign(dividend)≠sign(divisor).
  - Remainder sign fix: negate if signed and dividend negative.
  - div_by_zero: quotient=0xFFFFFFFF, remainder=original dividend (signed or unsigned).
  - Overflow (0x80000000 / 0xFFFFFFFF signed) falls out naturally: quotient=0x80000000, remainder=0. No special path required, but the result must match.
- out_result = get_rem ? remainder : quotient when out_valid; 0 when out_valid=0. out_rd = stage7 rd.
- rd=0 ops are processed normally and do emit out_valid; writeback discards writes to x0. div_busy_k still shows rd=0, and decode ignores it.
- div_busy_k = {stage_k.valid, 1'b0, stage_k.rd}, purely registered (no combinational path from in_*).
- Reset: all stage registers cleared. All div_busy_k=7'b0; out_valid=0, out_rd=0, out_result=0 in the cycle after the rst edge.
- rst mid-operation drops every in-flight op; no out_valid is produced for them. in_valid during rst is ignored.
- Bubbles (in_valid=0) propagate as valid=0; data fields of invalid stages may toggle but must not affect outputs.

Test Plan:
- DIVU 100/7, rd=5 issued at cycle 0 → div_busy_k=7'b1000101 in cycle k+1. Cycle 8: out_valid=1, out_rd=5, out_result=14. REMU same operands → 2.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIV 7/-2 → 0xFFFFFFFD. REM 7/-2 → 1.
- Divide by zero: DIV 0x1234/0 → 0xFFFFFFFF. REMU 0x1234/0 → 0x1234. REM 0xFFFFFF00/0 → 0xFFFFFF00.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0. DIVU same operands → 0.
- 8 back-to-back ops, rd=1..8, random operands checked against a reference model → all div_busy valid in cycle 8; results emerge in issue order on 8 consecutive cycles. A bubble in the input stream gives exactly one out_valid=0 gap.
- 3 ops in flight, rst pulsed one cycle → next cycle all div_busy=0, out_valid=0. No stale result ever appears. A new op issued after reset completes in 8 cycles with correct value.

Source files
------------

// File: rtl/div_pipe_unit.sv
// Eight-stage restoring divider for RV32M DIV/DIVU/REM/REMU.
// Each stage resolves four quotient bits, so one op is accepted per cycle and its result appears 8 cycles later.
module div_pipe_unit #(
   parameter int WIDTH          = 32,
   parameter int STAGES         = 8,
   parameter int BITS_PER_STAGE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_signed,
   input  logic             in_get_rem,
   input  logic [4:0]       in_rd,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic [6:0]       div_busy_0,
   output logic [6:0]       div_busy_1,
   output logic [6:0]       div_busy_2,
   output logic [6:0]       div_busy_3,
   output logic [6:0]       div_busy_4,
   output logic [6:0]       div_busy_5,
   output logic [6:0]       div_busy_6,
   output logic [6:0]       div_busy_7,
   output logic             out_valid,
   output logic [4:0]       out_rd,
   output logic [WIDTH-1:0] out_result
);

   localparam int LAST = STAGES - 1;

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
      return en ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   // State is {partial remainder, quotient/shift register}.
   function automatic logic [2*WIDTH:0] div_step(input logic [2*WIDTH:0] st,
                                                 input logic [WIDTH-1:0] d);
      logic [WIDTH:0]   r;
      logic [WIDTH-1:0] q;
      r = st[2*WIDTH:WIDTH];
      q = st[WIDTH-1:0];
      for (int i = 0; i < BITS_PER_STAGE; i++) begin
         r = {r[WIDTH-1:0], q[WIDTH-1]};
         q = {q[WIDTH-2:0], 1'b0};
         if (r >= {1'b0, d}) begin
            r    = r - {1'b0, d};
            q[0] = 1'b1;
         end
      end
      return {r, q};
   endfunction

   logic             vld_p     [STAGES];
   logic             sgn_p     [STAGES];
   logic             get_rem_p [STAGES];
   logic [4:0]       rd_p      [STAGES];
   logic             a_sign_p  [STAGES];
   logic             b_sign_p  [STAGES];
   logic             dbz_p     [STAGES];
   logic [WIDTH-1:0] dmag_p    [STAGES];
   logic [WIDTH:0]   rem_p     [STAGES];
   logic [WIDTH-1:0] q_p       [STAGES];

   logic [2*WIDTH:0] nxt [STAGES];
   logic [WIDTH-1:0] a_mag, b_mag;

   // Stage 0 input: magnitudes (0x80000000 maps to unsigned 2^31) and first four iterations
   assign a_mag = neg_if(in_dividend, in_signed & in_dividend[WIDTH-1]);
   assign b_mag = neg_if(in_divisor, in_signed & in_divisor[WIDTH-1]);

   always_comb begin
      nxt[0] = div_step({{(WIDTH+1){1'b0}}, a_mag}, b_mag);
      for (int k = 1; k < STAGES; k++)
         nxt[k] = div_step({rem_p[k-1], q_p[k-1]}, dmag_p[k-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_p[k]     <= 1'b0;
            sgn_p[k]     <= 1'b0;
            get_rem_p[k] <= 1'b0;
            rd_p[k]      <= '0;
            a_sign_p[k]  <= 1'b0;
            b_sign_p[k]  <= 1'b0;
            dbz_p[k]     <= 1'b0;
            dmag_p[k]    <= '0;
            rem_p[k]     <= '0;
            q_p[k]       <= '0;
         end
      end else begin
         vld_p[0]               <= in_valid;
         sgn_p[0]               <= in_signed;
         get_rem_p[0]           <= in_get_rem;
         rd_p[0]                <= in_rd;
         a_sign_p[0]            <= in_dividend[WIDTH-1];
         b_sign_p[0]            <= in_divisor[WIDTH-1];
         dbz_p[0]               <= (in_divisor == '0);
         dmag_p[0]              <= b_mag;
         {rem_p[0], q_p[0]}     <= nxt[0];
         // Stages 1..7: four more iterations each, control fields ride along
         for (int k = 1; k < STAGES; k++) begin
            vld_p[k]           <= vld_p[k-1];
            sgn_p[k]           <= sgn_p[k-1];
            get_rem_p[k]       <= get_rem_p[k-1];
            rd_p[k]            <= rd_p[k-1];
            a_sign_p[k]        <= a_sign_p[k-1];
            b_sign_p[k]        <= b_sign_p[k-1];
            dbz_p[k]           <= dbz_p[k-1];
            dmag_p[k]          <= dmag_p[k-1];
            {rem_p[k], q_p[k]} <= nxt[k];
         end
      end
   end

   // Output from stage 7. With a zero divisor the remainder magnitude equals |dividend|,
   // so the normal remainder sign fix already restores the original dividend.
   logic [WIDTH-1:0] quo, rmd;
   logic             q_neg, r_neg;

   assign q_neg = sgn_p[LAST] & (a_sign_p[LAST] ^ b_sign_p[LAST]);
   assign r_neg = sgn_p[LAST] & a_sign_p[LAST];
   assign quo   = dbz_p[LAST] ? {WIDTH{1'b1}} : neg_if(q_p[LAST], q_neg);
   assign rmd   = neg_if(rem_p[LAST][WIDTH-1:0], r_neg);

   assign out_valid  = vld_p[LAST];
   assign out_rd     = rd_p[LAST];
   assign out_result = vld_p[LAST] ? (get_rem_p[LAST] ? rmd : quo) : '0;

   assign div_busy_0 = {vld_p[0], 1'b0, rd_p[0]};
   assign div_busy_1 = {vld_p[1], 1'b0, rd_p[1]};
   assign div_busy_2 = {vld_p[2], 1'b0, rd_p[2]};
   assign div_busy_3 = {vld_p[3], 1'b0, rd_p[3]};
   assign div_busy_4 = {vld_p[4], 1'b0, rd_p[4]};
   assign div_busy_5 = {vld_p[5], 1'b0, rd_p[5]};
   assign div_busy_6 = {vld_p[6], 1'b0, rd_p[6]};
   assign div_busy_7 = {vld_p[7], 1'b0, rd_p[7]};

endmodule
